// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: bus widths, status
// bit positions, FSM encoding and the burst address helper.
package spi_pkg;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int ST_WE    = 2;
    localparam int ST_BURST = 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_REQ     = 3'd1,
        S_WR_WAIT    = 3'd2,
        S_WR_REQ     = 3'd3,
        S_BURST_WAIT = 3'd4
    } bridge_state_t;

    // Burst address step; wraps naturally at the top of the 20-bit space
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + 20'd1;
    endfunction

endpackage

// File: rtl/spi_bus_timeout.sv
// Bus request watchdog: cleared on load, counts while enabled, and flags the
// last cycle of the allowed request window.
module spi_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter for the current request; idles at zero between requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= {CNT_W{1'b0}};
        end
    end

    assign expired = enable & (count_r == LAST_CNT);

endmodule

// File: rtl/spi_bus_bridge.sv
// Turns decoded SPI frames into single-outstanding request/ack transactions on
// the internal register bus, with burst increment, timeout and frame abort.
module spi_bus_bridge
    import spi_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 15,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              address_ready,
    input  logic              data_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              busy,
    output logic              err_flag,
    input  logic              err_clr
);

    logic              cs_meta_r, cs_sync_r;
    bridge_state_t     state_r, state_s;
    logic [ADDR_W-1:0] addr_q_r, addr_q_s;
    logic [DATA_W-1:0] wdata_q_r, wdata_q_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              we_q_r, we_q_s;
    logic              burst_q_r, burst_q_s;
    logic              abort_seen_r, abort_seen_s;
    logic              bus_req_r, bus_req_s;
    logic              busy_r, busy_s;
    logic              err_flag_r, err_flag_s;
    logic              err_set_s;
    logic              done_s;
    logic              tmo_load_s, tmo_expired_s;

    // cs_n crosses from the SCLK domain; resets to deselected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_r <= 1'b1;
            cs_sync_r <= 1'b1;
        end else begin
            cs_meta_r <= cs_n;
            cs_sync_r <= cs_meta_r;
        end
    end

    spi_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (8)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tmo_load_s),
        .enable (bus_req_r),
        .expired(tmo_expired_s)
    );

    // Next-state and next-output logic; all outputs are registered from these
    always_comb begin
        state_s      = state_r;
        addr_q_s     = addr_q_r;
        wdata_q_s    = wdata_q_r;
        rdata_s      = rdata_r;
        we_q_s       = we_q_r;
        burst_q_s    = burst_q_r;
        abort_seen_s = 1'b0;
        err_set_s    = 1'b0;
        done_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (address_ready) begin
                    addr_q_s  = addr;
                    we_q_s    = status[ST_WE];
                    burst_q_s = status[ST_BURST];
                    state_s   = status[ST_WE] ? S_WR_WAIT : S_RD_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                abort_seen_s = abort_seen_r | cs_sync_r;
                done_s       = bus_ack | tmo_expired_s;
                // ack wins over a simultaneous timeout
                if (bus_ack) begin
                    err_set_s = data_ready | bus_err;
                    if (state_r == S_RD_REQ) begin
                        rdata_s = bus_err ? ERR_RDATA : bus_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (tmo_expired_s) begin
                    err_set_s = 1'b1;
                    if (state_r == S_RD_REQ) begin
                        rdata_s = ERR_RDATA;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    err_set_s = data_ready;
                end
                if (done_s) begin
                    if (burst_q_r && !abort_seen_r && !cs_sync_r) begin
                        state_s = S_BURST_WAIT;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_WR_WAIT: begin
                if (cs_sync_r) begin
                    state_s = S_IDLE;
                end else if (data_ready) begin
                    wdata_q_s = wdata;
                    state_s   = S_WR_REQ;
                end else begin
                    state_s = S_WR_WAIT;
                end
            end
            S_BURST_WAIT: begin
                if (cs_sync_r) begin
                    state_s = S_IDLE;
                end else if (data_ready) begin
                    addr_q_s = addr_next(addr_q_r);
                    if (we_q_r) begin
                        wdata_q_s = wdata;
                        state_s   = S_WR_REQ;
                    end else begin
                        state_s = S_RD_REQ;
                    end
                end else begin
                    state_s = S_BURST_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        bus_req_s  = (state_s == S_RD_REQ) || (state_s == S_WR_REQ);
        busy_s     = (state_s != S_IDLE);
        tmo_load_s = bus_req_s & ~bus_req_r;

        if (err_set_s) begin
            err_flag_s = 1'b1;
        end else if (err_clr) begin
            err_flag_s = 1'b0;
        end else begin
            err_flag_s = err_flag_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            addr_q_r     <= 20'h00000;
            wdata_q_r    <= 16'h0000;
            rdata_r      <= 16'h0000;
            we_q_r       <= 1'b0;
            burst_q_r    <= 1'b0;
            abort_seen_r <= 1'b0;
            bus_req_r    <= 1'b0;
            busy_r       <= 1'b0;
            err_flag_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_q_r     <= addr_q_s;
            wdata_q_r    <= wdata_q_s;
            rdata_r      <= rdata_s;
            we_q_r       <= we_q_s;
            burst_q_r    <= burst_q_s;
            abort_seen_r <= abort_seen_s;
            bus_req_r    <= bus_req_s;
            busy_r       <= busy_s;
            err_flag_r   <= err_flag_s;
        end
    end

    assign rdata     = rdata_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = we_q_r;
    assign bus_addr  = addr_q_r;
    assign bus_wdata = wdata_q_r;
    assign busy      = busy_r;
    assign err_flag  = err_flag_r;

endmodule
